// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle divider and its ALU control codes.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  // ALU control codes; the ALU hands DIV/DIVU off to div_unit.
  localparam logic [3:0] ALU_ADD_CONTROL  = 4'd0;
  localparam logic [3:0] ALU_SUB_CONTROL  = 4'd1;
  localparam logic [3:0] ALU_AND_CONTROL  = 4'd2;
  localparam logic [3:0] ALU_OR_CONTROL   = 4'd3;
  localparam logic [3:0] ALU_SLT_CONTROL  = 4'd4;
  localparam logic [3:0] MULT_CONTROL     = 4'd5;
  localparam logic [3:0] MULTU_CONTROL    = 4'd6;
  localparam logic [3:0] DIV_CONTROL      = 4'd7;
  localparam logic [3:0] DIVU_CONTROL     = 4'd8;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: request/operands in, busy/ready and HI/LO result out.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             annul;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, signed_div, dividend, divisor, annul,
    input  busy, ready, hi_out, lo_out
  );

  modport slave (
    input  start, signed_div, dividend, divisor, annul,
    output busy, ready, hi_out, lo_out
  );
endinterface

// File: rtl/div_unit_clz32.sv
// Combinational 32-bit leading-zero counter (32 for an all-zero input); used only with DIV_EARLY_TERM_EN.
module clz32 (
  input  logic [31:0] a_i,
  output logic [5:0]  z_o
);
  always_comb begin
    z_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a_i[i]) z_o = 6'(31 - i);
    end
  end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU returning hi=remainder, lo=quotient.
// Optional DIV_EARLY_TERM_EN skips the leading-zero iterations of |dividend|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             q_neg_q, r_neg_q;
  logic             busy_q, ready_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic signed [WIDTH-1:0] dvd_s, dvs_s;
  logic [WIDTH-1:0]        dvd_abs, dvs_abs;
  logic [WIDTH-1:0]        quo_init;
  logic [CNT_W-1:0]        cnt_init;
  logic [WIDTH:0]          trial, diff;
  logic [WIDTH-1:0]        rem_d, quo_d;

  function automatic logic [WIDTH-1:0] abs_op(input logic signed [WIDTH-1:0] x,
                                              input logic is_signed);
    logic [WIDTH-1:0] r;
    r = (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign dvd_s   = $signed(bus.dividend);
  assign dvs_s   = $signed(bus.divisor);
  assign dvd_abs = abs_op(dvd_s, bus.signed_div);
  assign dvs_abs = abs_op(dvs_s, bus.signed_div);

`ifdef DIV_EARLY_TERM_EN
  logic [5:0] lz;
  clz32 u_clz (.a_i(dvd_abs), .z_o(lz));
  assign quo_init = dvd_abs << lz;
  assign cnt_init = CNT_W'(lz);
`else
  assign quo_init = dvd_abs;
  assign cnt_init = '0;
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract, keep on no-borrow.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvsr_q};
    rem_d = trial[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      busy_q  <= (state_q == DIV_ON) || (state_q == DIV_BYZERO);
      ready_q <= (state_q == DIV_END);
      case (state_q)
        DIV_IDLE: begin
          if (bus.start && !bus.annul) begin
            if (bus.divisor == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_ON;
              rem_q   <= '0;
              quo_q   <= quo_init;
              dvsr_q  <= dvs_abs;
              cnt_q   <= cnt_init;
              q_neg_q <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              r_neg_q <= bus.signed_div & bus.dividend[WIDTH-1];
            end
          end
        end
        DIV_BYZERO: begin
          if (bus.annul) begin
            state_q <= DIV_IDLE;
          end else begin
            state_q <= DIV_END;
            hi_q    <= '0;
            lo_q    <= '0;
          end
        end
        DIV_ON: begin
          if (bus.annul) begin
            state_q <= DIV_IDLE;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            state_q <= DIV_END;
            hi_q    <= neg_if(rem_q, r_neg_q);
            lo_q    <= neg_if(quo_q, q_neg_q);
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV_END: begin
          if (bus.annul || !bus.start) state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit (latency expectations follow DIV_EARLY_TERM_EN).
module tb_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DIV_EARLY_TERM_EN
  localparam int ANNUL_EDGE = 3;
`else
  localparam int ANNUL_EDGE = 10;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int lead_zeros(input logic [31:0] x);
    int z;
    z = 0;
    while (z < 32 && !x[31 - z]) z++;
    return z;
  endfunction

  function automatic int exp_lat(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    if (b == 32'd0) return 2;
    mag = (sd && a[31]) ? (32'd0 - a) : a;
`ifdef DIV_EARLY_TERM_EN
    return 34 - lead_zeros(mag);
`else
    return (mag === mag) ? 34 : 34;
`endif
  endfunction

  function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sbv, q, r;
    if (b == 32'd0) begin
      hi = '0;
      lo = '0;
    end else if (sd) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      lo  = q[31:0];
      hi  = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.dividend   = a;
    bus.divisor    = b;
    @(posedge clk);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.signed_div = ~sd;
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
  endtask

  task automatic wait_ready(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic run(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    int   n, bcnt;
    e.hi  = ehi;
    e.lo  = elo;
    e.lat = exp_lat(sd, a, b);
    sb.push_back(e);
    issue(sd, a, b);
    wait_ready(n, bcnt);
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(n), 64'(e.lat));
    check({tag, "_busycyc"}, 64'(bcnt), 64'(e.lat - 1));
    check({tag, "_busy_at_rdy"}, 64'(bus.busy), 64'(0));
    check({tag, "_hi"}, 64'(bus.hi_out), 64'(e.hi));
    check({tag, "_lo"}, 64'(bus.lo_out), 64'(e.lo));
  endtask

  initial begin
    exp_t        e;
    int          n;
    logic        rdy_seen;
    logic        sd;
    logic [31:0] a, b, mh, ml;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.annul      = 1'b0;
    #13;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_ready", 64'(bus.ready), 64'(0));
    check("rst_hi", 64'(bus.hi_out), 64'(0));
    check("rst_lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run("divu_7_2", 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    run("divu_0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0);
    run("divu_1_1", 1'b0, 32'd1, 32'd1, 32'd0, 32'd1);

    // Divide by zero with start held high through END.
    e.hi = '0; e.lo = '0; e.lat = 2;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd5; bus.divisor = 32'd0;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check("byzero_lat", 64'(n), 64'(e.lat));
    check("byzero_hi", 64'(bus.hi_out), 64'(e.hi));
    check("byzero_lo", 64'(bus.lo_out), 64'(e.lo));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.ready), 64'(1));
      check("hold_hi", 64'(bus.hi_out), 64'(0));
      check("hold_lo", 64'(bus.lo_out), 64'(0));
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drop_start_ready", 64'(bus.ready), 64'(0));

    // Annul mid-divide: no result, busy drops the following cycle.
    issue(1'b0, 32'd100, 32'd3);
    rdy_seen = 1'b0;
    for (int k = 1; k < ANNUL_EDGE; k++) begin
      @(negedge clk);
      if (bus.ready) rdy_seen = 1'b1;
    end
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check("annul_busy_edge", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check("annul_busy_low", 64'(bus.busy), 64'(0));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) rdy_seen = 1'b1;
    end
    check("annul_no_ready", 64'(rdy_seen), 64'(0));
    run("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3);

    for (int k = 0; k < 6; k++) begin
      sd = k[0];
      a  = $urandom;
      b  = (k < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (sd && k == 5) b = 32'hFFFF_FFF0 | 32'($urandom_range(1, 15));
      model(sd, a, b, mh, ml);
      run("rand", sd, a, b, mh, ml);
    end

    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

    // Asynchronous reset in the middle of a divide.
    issue(1'b0, 32'hFFFF_0000, 32'd3);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_ready", 64'(bus.ready), 64'(0));
    check("arst_hi", 64'(bus.hi_out), 64'(0));
    check("arst_lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run("post_rst_1_1", 1'b0, 32'd1, 32'd1, 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider that handles DIV/DIVU. The ALU leaves these operations to this block.
- Takes operands from the execute stage and returns {remainder, quotient} in the same HI/LO format the ALU's multiplier produces (hi = remainder, lo = quotient).
- Raises busy so pipeline control stalls execute until the result is ready.

Parameters:
- WIDTH, 32, operand width. Quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- signed_div  input  1  1 = DIV (signed), 0 = DIVU
- dividend  input  WIDTH  rs operand, sampled with start
- divisor  input  WIDTH  rt operand, sampled with start
- annul  input  1  cancel the in-flight divide (exception or flush)
- busy  output  1  high in BYZERO and ON states
- ready  output  1  result valid, registered
- hi_out  output  WIDTH  remainder
- lo_out  output  WIDTH  quotient

Behaviour:
- Reset: async. State goes to IDLE; busy, ready, hi_out, lo_out, cnt and all datapath registers go to 0.
- States: IDLE, BYZERO, ON, END. busy and ready are decoded from state and registered.
- IDLE:
  - start=1 and annul=0, divisor==0 → BYZERO.
  - start=1 and annul=0, divisor!=0 → ON. Latch |dividend| and |divisor| (absolute values only when signed_div=1). Latch the sign flags, clear partial remainder, cnt=0.
- ON:
  - While cnt<WIDTH, one iteration per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, restore on borrow, set the quotient bit, cnt++.
  - When cnt==WIDTH → END and register the results.
  - Sign correction, signed only: quotient is negated if dividend sign XOR divisor sign. Remainder is negated if the dividend is negative, so the remainder takes the dividend's sign.
- BYZERO: next cycle → END with hi_out=0, lo_out=0. No exception is raised; the result is architecturally undefined and we fix it to 0.
- END:
  - ready=1 and outputs hold.
  - Stays in END while start=1.
  - start=0 → IDLE, ready=0 next cycle.
- annul:
  - In ON or BYZERO → IDLE next cycle; ready never asserts and outputs are not updated.
  - In END → IDLE.
  - In IDLE, annul blocks start.
- Latency, without the optional feature:
  - Start sampled at edge 0 gives ready high after edge WIDTH+2 (34).
  - Divide by zero gives ready after edge 2.
- Operands are ignored after sampling; input changes mid-operation have no effect.
- Signed overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no overflow flag.
- The result is held in END until the next start, so a stall release one cycle late is safe.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- Defined:
  - In IDLE at start, count leading zeros z of |dividend| (z=WIDTH if zero).
  - Pre-shift |dividend| left by z and initialise cnt=z.
  - Latency becomes WIDTH+2−z; a zero dividend gives ready after 2 edges. Results are identical.
- Undefined: fixed latency, and the leading-zero logic is absent.

Decomposition:
- Shared constants in configs.vh:
  - state encodings DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_END
  - DIV_WIDTH=32
  - DIV_CONTROL/DIVU_CONTROL codes alongside the existing ALU control codes
- Sub-module clz32: combinational leading-zero counter, 32-bit input, 6-bit output. Instantiated only under DIV_EARLY_TERM_EN.

Test Plan:
- DIVU 7/2, start one cycle → ready after 34 cycles, lo=0x00000003, hi=0x00000001; busy high for cycles 1–33.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/−2 → lo=0xFFFFFFFD, hi=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000. DIVU 0xFFFFFFFF / 0x10 → lo=0x0FFFFFFF, hi=0xF.
- DIVU 5/0 → ready after 2 cycles, hi=lo=0. Hold start high 5 cycles → ready and outputs stay constant; drop start → ready low next cycle.
- DIVU 100/3, annul at cycle 10 → busy low at cycle 11, ready never rises. Immediate new DIVU 9/3 → lo=3, hi=0.
- rst asserted asynchronously mid-ON → busy, ready and outputs go to 0 immediately. With DIV_EARLY_TERM_EN, DIVU 1/1 → ready after 3 cycles, lo=1, hi=0.
